// File: rtl/drive_arbiter.sv
// Drive arbiter: selects between Arduino manual commands and the autonomous planner,
// blanking the motor to STOP on every mode switch. Optional manual watchdog: DRIVE_ARBITER_WATCHDOG_EN.
module drive_arbiter #(
    parameter int unsigned BLANK_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    input  logic       auto_valid,
    input  logic [2:0] auto_cmd,
    output logic       auto_ready,
    output logic [2:0] motor_cmd,
    output logic       manual_on,
    output logic       auto_on,
    output logic       switching,
    output logic       wd_trip
);

    localparam int unsigned BLANK_W = 8;
    localparam int unsigned WD_W    = 26;
    localparam logic [2:0]         MOTOR_STOP = 3'd0;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_MANUAL,
        ST_AUTO,
        ST_SWITCH
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         motor_q, motor_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               target_auto_q, target_auto_d;
    logic               manual_on_q, manual_on_d;
    logic               auto_on_q, auto_on_d;
    logic               switching_q, switching_d;

    logic       go_manual;
    logic       go_auto;
    logic       is_move;
    logic [2:0] move_code;
    logic [2:0] auto_code;

`ifdef DRIVE_ARBITER_WATCHDOG_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_trip_q, wd_trip_d;
`endif

    // Command byte decode
    always_comb begin
        go_manual = cmd_valid && (cmd_data == 8'h00);
        go_auto   = cmd_valid && (cmd_data == 8'hFF);
        is_move   = cmd_valid && (cmd_data >= 8'h01) && (cmd_data <= 8'h05);
        move_code = (cmd_data == 8'h05) ? MOTOR_STOP : cmd_data[2:0];
        auto_code = (auto_cmd > 3'd4) ? MOTOR_STOP : auto_cmd;
    end

    // Next-state, motor and handshake logic
    always_comb begin
        state_d       = state_q;
        motor_d       = motor_q;
        blank_d       = blank_q;
        target_auto_d = target_auto_q;
        auto_ready    = 1'b0;
`ifdef DRIVE_ARBITER_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        wd_trip_d     = wd_trip_q;
`endif

        case (state_q)
            ST_INIT: begin
                motor_d = MOTOR_STOP;
                if (go_manual) state_d = ST_MANUAL;
            end
            ST_MANUAL: begin
                if (go_auto) begin
                    state_d       = ST_SWITCH;
                    target_auto_d = 1'b1;
                    blank_d       = BLANK_LOAD;
                    motor_d       = MOTOR_STOP;
                end else if (is_move) begin
                    motor_d = move_code;
                end
            end
            ST_AUTO: begin
                // A manual request in the same cycle wins over the planner handshake
                auto_ready = !go_manual;
                if (go_manual) begin
                    state_d       = ST_SWITCH;
                    target_auto_d = 1'b0;
                    blank_d       = BLANK_LOAD;
                    motor_d       = MOTOR_STOP;
                end else if (auto_valid) begin
                    motor_d = auto_code;
                end
            end
            ST_SWITCH: begin
                motor_d = MOTOR_STOP;
                if (go_manual || go_auto) begin
                    target_auto_d = go_auto;
                    blank_d       = BLANK_LOAD;
                end else if (blank_q == '0) begin
                    state_d = target_auto_q ? ST_AUTO : ST_MANUAL;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                motor_d = MOTOR_STOP;
            end
        endcase

`ifdef DRIVE_ARBITER_WATCHDOG_EN
        // Idle-time watchdog, only live while staying in MANUAL
        if ((state_q == ST_MANUAL) && (state_d == ST_MANUAL)) begin
            if (is_move) begin
                wd_cnt_d  = '0;
                wd_trip_d = 1'b0;
            end else if (wd_cnt_q != WD_LIMIT) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
            if (wd_cnt_d == WD_LIMIT) begin
                motor_d   = MOTOR_STOP;
                wd_trip_d = 1'b1;
            end
        end else begin
            wd_cnt_d  = '0;
            wd_trip_d = 1'b0;
        end
`endif

        manual_on_d = (state_d == ST_MANUAL);
        auto_on_d   = (state_d == ST_AUTO);
        switching_d = (state_d == ST_SWITCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            motor_q       <= MOTOR_STOP;
            blank_q       <= '0;
            target_auto_q <= 1'b0;
            manual_on_q   <= 1'b0;
            auto_on_q     <= 1'b0;
            switching_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            motor_q       <= motor_d;
            blank_q       <= blank_d;
            target_auto_q <= target_auto_d;
            manual_on_q   <= manual_on_d;
            auto_on_q     <= auto_on_d;
            switching_q   <= switching_d;
        end
    end

`ifdef DRIVE_ARBITER_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_trip_q <= wd_trip_d;
        end
    end

    assign wd_trip = wd_trip_q;
`else
    assign wd_trip = 1'b0;
`endif

    assign motor_cmd = motor_q;
    assign manual_on = manual_on_q;
    assign auto_on   = auto_on_q;
    assign switching = switching_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter (BLANK_CYCLES=4, TIMEOUT_CYCLES=100); expectations
// follow DRIVE_ARBITER_WATCHDOG_EN when it is defined for the build.
module tb_drive_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       auto_valid;
    logic [2:0] auto_cmd;
    logic       auto_ready;
    logic [2:0] motor_cmd;
    logic       manual_on;
    logic       auto_on;
    logic       switching;
    logic       wd_trip;

    int total = 0;
    int bad   = 0;

    drive_arbiter #(
        .BLANK_CYCLES  (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .auto_valid(auto_valid),
        .auto_cmd  (auto_cmd),
        .auto_ready(auto_ready),
        .motor_cmd (motor_cmd),
        .manual_on (manual_on),
        .auto_on   (auto_on),
        .switching (switching),
        .wd_trip   (wd_trip)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // One-cycle command strobe; returns at the negedge after the sampling edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h00; auto_valid = 1'b1; auto_cmd = 3'd1;
        #1;
        total++; if ({manual_on, auto_on, switching} !== 3'b000) begin bad++; $display("FAIL rst_state got=%b want=000", {manual_on, auto_on, switching}); end
        repeat (2) tick();
        total++; if (motor_cmd !== 3'd0) begin bad++; $display("FAIL rst_motor got=%0d want=0", motor_cmd); end
        total++; if (auto_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", auto_ready); end
        total++; if ({manual_on, wd_trip} !== 2'b00) begin bad++; $display("FAIL rst_hold got=%b want=00", {manual_on, wd_trip}); end
        cmd_valid = 1'b0; auto_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_power_up();
        send(8'h01);
        total++; if ({manual_on, auto_on, switching} !== 3'b000) begin bad++; $display("FAIL pwr_ignore01 got=%b want=000", {manual_on, auto_on, switching}); end
        send(8'hFF);
        total++; if ({manual_on, auto_on, switching} !== 3'b000) begin bad++; $display("FAIL pwr_ignoreFF got=%b want=000", {manual_on, auto_on, switching}); end
        send(8'h00);
        total++; if ({manual_on, auto_on, switching} !== 3'b100) begin bad++; $display("FAIL pwr_manual got=%b want=100", {manual_on, auto_on, switching}); end
        total++; if (motor_cmd !== 3'd0) begin bad++; $display("FAIL pwr_motor got=%0d want=0", motor_cmd); end
    endtask

    task automatic test_manual_drive();
        send(8'h03);
        total++; if (motor_cmd !== 3'd3) begin bad++; $display("FAIL man_left got=%0d want=3", motor_cmd); end
        send(8'h07);
        total++; if (motor_cmd !== 3'd3) begin bad++; $display("FAIL man_ignore07 got=%0d want=3", motor_cmd); end
        send(8'h00);
        total++; if ({manual_on, motor_cmd} !== {1'b1, 3'd3}) begin bad++; $display("FAIL man_stay got=%b want=1011", {manual_on, motor_cmd}); end
        send(8'h05);
        total++; if (motor_cmd !== 3'd0) begin bad++; $display("FAIL man_stop got=%0d want=0", motor_cmd); end
    endtask

    task automatic test_manual_to_auto();
        send(8'h01);
        total++; if (motor_cmd !== 3'd1) begin bad++; $display("FAIL m2a_fwd got=%0d want=1", motor_cmd); end
        send(8'hFF);
        auto_valid = 1'b1; auto_cmd = 3'd2;
        for (int i = 0; i < 4; i++) begin
            total++; if ({switching, motor_cmd, auto_ready} !== {1'b1, 3'd0, 1'b0}) begin bad++; $display("FAIL m2a_blank%0d got=%b want=10000", i, {switching, motor_cmd, auto_ready}); end
            if (i == 3) auto_valid = 1'b0;
            tick();
        end
        total++; if ({manual_on, auto_on, switching, motor_cmd} !== {3'b010, 3'd0}) begin bad++; $display("FAIL m2a_auto got=%b want=010000", {manual_on, auto_on, switching, motor_cmd}); end
        auto_valid = 1'b1; auto_cmd = 3'd4;
        #1;
        total++; if (auto_ready !== 1'b1) begin bad++; $display("FAIL m2a_ready got=%b want=1", auto_ready); end
        tick();
        auto_valid = 1'b0;
        total++; if (motor_cmd !== 3'd4) begin bad++; $display("FAIL m2a_cmd4 got=%0d want=4", motor_cmd); end
        auto_valid = 1'b1; auto_cmd = 3'd6;
        tick();
        auto_valid = 1'b0;
        total++; if (motor_cmd !== 3'd0) begin bad++; $display("FAIL m2a_cmd6 got=%0d want=0", motor_cmd); end
        auto_valid = 1'b1; auto_cmd = 3'd3;
        tick();
        auto_valid = 1'b0;
        send(8'h02);
        total++; if ({auto_on, motor_cmd} !== {1'b1, 3'd3}) begin bad++; $display("FAIL m2a_ignore02 got=%b want=1011", {auto_on, motor_cmd}); end
    endtask

    task automatic test_collision_retarget();
        tick();
        cmd_valid = 1'b1; cmd_data = 8'h00; auto_valid = 1'b1; auto_cmd = 3'd1;
        #1;
        total++; if (auto_ready !== 1'b0) begin bad++; $display("FAIL col_ready got=%b want=0", auto_ready); end
        tick();
        cmd_valid = 1'b0; auto_valid = 1'b0;
        total++; if ({switching, motor_cmd} !== {1'b1, 3'd0}) begin bad++; $display("FAIL col_switch got=%b want=1000", {switching, motor_cmd}); end
        tick();
        send(8'hFF);
        for (int i = 0; i < 4; i++) begin
            total++; if ({switching, auto_on, manual_on} !== 3'b100) begin bad++; $display("FAIL col_blank%0d got=%b want=100", i, {switching, auto_on, manual_on}); end
            tick();
        end
        total++; if ({manual_on, auto_on, switching, motor_cmd} !== {3'b010, 3'd0}) begin bad++; $display("FAIL col_auto got=%b want=010000", {manual_on, auto_on, switching, motor_cmd}); end
    endtask

    task automatic test_watchdog();
        send(8'h00);
        repeat (4) tick();
        total++; if ({manual_on, auto_on, switching} !== 3'b100) begin bad++; $display("FAIL wd_manual got=%b want=100", {manual_on, auto_on, switching}); end
        send(8'h01);
        repeat (99) tick();
        total++; if ({motor_cmd, wd_trip} !== {3'd1, 1'b0}) begin bad++; $display("FAIL wd_pre got=%b want=0010", {motor_cmd, wd_trip}); end
        tick();
`ifdef DRIVE_ARBITER_WATCHDOG_EN
        total++; if ({motor_cmd, wd_trip} !== {3'd0, 1'b1}) begin bad++; $display("FAIL wd_trip got=%b want=0001", {motor_cmd, wd_trip}); end
`else
        total++; if ({motor_cmd, wd_trip} !== {3'd1, 1'b0}) begin bad++; $display("FAIL wd_notrip got=%b want=0010", {motor_cmd, wd_trip}); end
`endif
        send(8'h02);
        total++; if ({motor_cmd, wd_trip} !== {3'd2, 1'b0}) begin bad++; $display("FAIL wd_clear got=%b want=0100", {motor_cmd, wd_trip}); end
    endtask

    task automatic test_reset_mid_switch();
        send(8'hFF);
        tick();
        total++; if ({switching, motor_cmd} !== {1'b1, 3'd0}) begin bad++; $display("FAIL rms_pre got=%b want=1000", {switching, motor_cmd}); end
        #2 reset = 1'b1;
        #1;
        total++; if ({manual_on, auto_on, switching, motor_cmd, auto_ready, wd_trip} !== 8'd0) begin bad++; $display("FAIL rms_async got=%b want=00000000", {manual_on, auto_on, switching, motor_cmd, auto_ready, wd_trip}); end
        tick();
        reset = 1'b0;
        repeat (6) tick();
        total++; if ({manual_on, auto_on, switching} !== 3'b000) begin bad++; $display("FAIL rms_init got=%b want=000", {manual_on, auto_on, switching}); end
        send(8'h00);
        total++; if ({manual_on, auto_on, switching} !== 3'b100) begin bad++; $display("FAIL rms_manual got=%b want=100", {manual_on, auto_on, switching}); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; auto_valid = 1'b0; auto_cmd = 3'd0;
        test_reset();
        test_power_up();
        test_manual_drive();
        test_manual_to_auto();
        test_collision_retarget();
        test_watchdog();
        test_reset_mid_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
